// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Round-robin front end that shares one external pipelined signed
//   multiplier among NUM_REQ requesters. At most one operand pair is issued
//   per cycle; a shadow pipe of requester tags travels alongside the
//   multiplier so each result is steered back to its owner with a one-hot
//   resp_valid. Each requester may have at most MAX_OUT ops in flight.
//
//   Handshake: requester i hands over its operand pair in any cycle where
//   req_valid[i] && req_ready[i]. req_ready is a combinational function of
//   req_valid, the outstanding counts and the round-robin pointer; it is
//   never raised without req_valid and is forced low while reset is high.
//   Results have no backpressure: resp_valid[i] must be taken when shown.
//
//   Optional build macro MULT_ARB_PERF_EN adds saturating perf_issue_cnt /
//   perf_stall_cnt outputs; without it the block is otherwise identical.
module mult_share_arbiter #(
  parameter int DATA_LEN     = 32,
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 3,
  parameter int MAX_OUT      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_LEN-1:0]   req_a,
  input  logic [NUM_REQ*DATA_LEN-1:0]   req_b,
  output logic [DATA_LEN-1:0]           mul_a,
  output logic [DATA_LEN-1:0]           mul_b,
  input  logic [DATA_LEN-1:0]           mul_result,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_LEN-1:0]           resp_data,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id
`ifdef MULT_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_issue_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  // Arbitration state
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [OUT_W-1:0]     out_cnt_q [NUM_REQ];
  logic [OUT_W-1:0]     out_cnt_d [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_id;
  logic                 issue;
  logic [DATA_LEN-1:0]  sel_a, sel_b;

  // Operand registers and tag shadow pipe
  logic [DATA_LEN-1:0]  mul_a_q, mul_b_q;
  logic [MULT_LATENCY-1:0] tag_vld_q;
  logic [ID_W-1:0]      tag_id_q [MULT_LATENCY];
  logic                 tag_exit_vld;
  logic [ID_W-1:0]      tag_exit_id;

  // Response registers
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [DATA_LEN-1:0]  resp_data_q;
  logic [ID_W-1:0]      resp_id_q;

  // A requester may compete only with a pair ready and room for one more op.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (out_cnt_q[i] < MAX_OUT_V) && !reset;
    end
  end

  // Round-robin search starting at rr_ptr, wrapping once around all requesters.
  always_comb begin
    logic [ID_W-1:0] cand;
    grant    = '0;
    grant_id = '0;
    issue    = 1'b0;
    cand     = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!issue && eligible[cand]) begin
        issue       = 1'b1;
        grant[cand] = 1'b1;
        grant_id    = cand;
      end
      cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
    end
  end

  // Pointer moves just past the winner; it holds when nothing is issued.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*DATA_LEN +: DATA_LEN];
        sel_b = req_b[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  // Outstanding count: +1 on issue, -1 when its result is presented, hold on both.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      out_cnt_d[i] = out_cnt_q[i];
      case ({grant[i], resp_valid_q[i]})
        2'b10:   out_cnt_d[i] = out_cnt_q[i] + 1'b1;
        2'b01:   out_cnt_d[i] = out_cnt_q[i] - 1'b1;
        default: out_cnt_d[i] = out_cnt_q[i];
      endcase
    end
  end

  assign tag_exit_vld = tag_vld_q[MULT_LATENCY-1];
  assign tag_exit_id  = tag_id_q[MULT_LATENCY-1];

  // One-hot steering of the result leaving the multiplier this cycle.
  always_comb begin
    resp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid_d[i] = tag_exit_vld && (tag_exit_id == ID_W'(i));
    end
  end

  // Pointer, operand registers and tag pipe; tags line up with mul_result.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      tag_vld_q <= '0;
      for (int s = 0; s < MULT_LATENCY; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (issue) begin
        mul_a_q <= sel_a;
        mul_b_q <= sel_b;
      end
      tag_vld_q[0] <= issue;
      tag_id_q[0]  <= grant_id;
      for (int s = 1; s < MULT_LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  // Per-requester in-flight counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        out_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        out_cnt_q[i] <= out_cnt_d[i];
      end
    end
  end

  // Response register: capture mul_result only when a valid tag exits.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      if (tag_exit_vld) begin
        resp_data_q <= mul_result;
        resp_id_q   <= tag_exit_id;
      end
    end
  end

`ifdef MULT_ARB_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_q;

  // Saturating counters: issued ops, and cycles where someone waited but nothing issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (issue && (perf_issue_q != 32'hFFFF_FFFF)) begin
        perf_issue_q <= perf_issue_q + 32'd1;
      end
      if (!issue && (|req_valid) && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_issue_cnt = perf_issue_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

  assign req_ready  = grant;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter (MAX_OUT=2 so the in-flight limit is reachable).
// A two-stage multiplier behind the operand registers completes the
// three-cycle multiply path. A cycle-level reference model derives grants,
// operand registers and responses from the arbitration rules; literal
// expectations pin the directed scenarios.
module tb_mult_share_arbiter;

  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int LAT = 3;
  localparam int MO  = 2;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a, req_b;
  logic [DW-1:0]     mul_a, mul_b, mul_result;
  logic [NR-1:0]     resp_valid;
  logic [DW-1:0]     resp_data;
  logic [1:0]        resp_id;
`ifdef MULT_ARB_PERF_EN
  logic [31:0]       perf_issue_cnt, perf_stall_cnt;
`endif

  logic [DW-1:0]     a_arr [NR];
  logic [DW-1:0]     b_arr [NR];
  logic [DW-1:0]     mp1;

  int tests_run;
  int tests_failed;
  bit chk_en;

  mult_share_arbiter #(
    .DATA_LEN(DW), .NUM_REQ(NR), .MULT_LATENCY(LAT), .MAX_OUT(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id)
`ifdef MULT_ARB_PERF_EN
    ,
    .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pack per-requester operands.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = a_arr[i];
      req_b[i*DW +: DW] = b_arr[i];
    end
  end

  // External multiplier: two stages after the DUT operand registers, never reset.
  always @(posedge clk) begin
    mp1        <= mul_a * mul_b;
    mul_result <= mp1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          due;
    int          id;
    logic [DW-1:0] val;
  } pend_t;

  pend_t         exp_q[$];
  int            m_rr;
  int            m_out [NR];
  logic [DW-1:0] m_mul_a, m_mul_b;
  int            m_issues, m_stalls;
  int            cyc;

  initial begin
    m_rr = 0; m_mul_a = '0; m_mul_b = '0; m_issues = 0; m_stalls = 0; cyc = 0;
    for (int i = 0; i < NR; i++) m_out[i] = 0;
  end

  // Evaluate expectations mid-cycle, then advance the model across the next edge.
  always @(negedge clk) begin
    int g, hit, cand;
    logic [NR-1:0] exp_ready, exp_rv;
    g = -1;
    hit = -1;
    exp_ready = '0;
    if (!reset) begin
      for (int k = 0; k < NR; k++) begin
        cand = (m_rr + k) % NR;
        if (g < 0 && req_valid[cand] && m_out[cand] < MO) g = cand;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    for (int j = 0; j < exp_q.size(); j++) begin
      if (exp_q[j].due == cyc) hit = j;
    end
    exp_rv = '0;
    if (hit >= 0) exp_rv[exp_q[hit].id] = 1'b1;

    if (chk_en) begin
      check("model_req_ready", 64'(req_ready), 64'(exp_ready));
      check("model_mul_a", 64'(mul_a), 64'(m_mul_a));
      check("model_mul_b", 64'(mul_b), 64'(m_mul_b));
      check("model_resp_valid", 64'(resp_valid), 64'(exp_rv));
      if (hit >= 0) begin
        check("model_resp_data", 64'(resp_data), 64'(exp_q[hit].val));
        check("model_resp_id", 64'(resp_id), 64'(exp_q[hit].id));
      end
    end

    if (reset) begin
      exp_q.delete();
      m_rr = 0; m_mul_a = '0; m_mul_b = '0; m_issues = 0; m_stalls = 0;
      for (int i = 0; i < NR; i++) m_out[i] = 0;
    end else begin
      if (hit >= 0) begin
        m_out[exp_q[hit].id]--;
        exp_q.delete(hit);
      end
      if (g >= 0) begin
        m_out[g]++;
        m_rr = (g + 1) % NR;
        m_mul_a = a_arr[g];
        m_mul_b = b_arr[g];
        exp_q.push_back('{due: cyc + 1 + LAT, id: g, val: DW'(a_arr[g] * b_arr[g])});
        m_issues++;
      end else if (|req_valid) begin
        m_stalls++;
      end
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  int order_tbl [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  bit ready_tbl [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [NR-1:0] pat_tbl [12] = '{4'b1010, 4'b0110, 4'b1111, 4'b0001, 4'b1100, 4'b1111,
                                  4'b0000, 4'b1001, 4'b0111, 4'b1111, 4'b0010, 4'b1011};

  initial begin
    tests_run = 0;
    tests_failed = 0;
    chk_en = 1'b0;
    reset = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NR; i++) begin a_arr[i] = '0; b_arr[i] = '0; end

    // Reset: valid requests during reset must be ignored.
    tick();
    req_valid = 4'hF;
    tick();
    tick();
    #2;
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_mul_a", 64'(mul_a), 64'h0);
    check("rst_mul_b", 64'(mul_b), 64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_resp_data", 64'(resp_data), 64'h0);
    check("rst_resp_id", 64'(resp_id), 64'h0);
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = '0;

    // Single op: 3 * -5 = -15
    tick();
    req_valid = 4'b0001;
    a_arr[0] = 32'd3;
    b_arr[0] = 32'hFFFF_FFFB;
    #2 check("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    #2;
    check("t1_mul_a", 64'(mul_a), 64'h3);
    check("t1_mul_b", 64'(mul_b), 64'hFFFF_FFFB);
    tick(); tick(); tick();
    #2;
    check("t1_resp_valid", 64'(resp_valid), 64'h1);
    check("t1_resp_data", 64'(resp_data), 64'hFFFF_FFF1);
    check("t1_resp_id", 64'(resp_id), 64'h0);

    // All four valid: rotating grants starting past the last winner (0)
    for (int k = 0; k < 8; k++) begin
      tick();
      req_valid = 4'hF;
      for (int i = 0; i < NR; i++) begin
        a_arr[i] = 32'(k * 16 + i + 1);
        b_arr[i] = 32'(-(k + i + 2));
      end
      #2;
      check("t2_grant", 64'(req_ready), 64'(1 << order_tbl[k]));
      if (k >= 4) begin
        check("t2_resp_id", 64'(resp_id), 64'(order_tbl[k-4]));
        check("t2_resp_valid", 64'(resp_valid), 64'(1 << order_tbl[k-4]));
      end
    end
    tick();
    req_valid = '0;
    repeat (8) tick();

    // In-flight limit: requester 1 alone, MAX_OUT=2
    for (int k = 0; k < 12; k++) begin
      tick();
      req_valid = 4'b0010;
      a_arr[1] = 32'(100 + k);
      b_arr[1] = 32'(k - 6);
      #2;
      if (k < 6) check("t3_ready1", 64'(req_ready[1]), 64'(ready_tbl[k]));
    end
    tick();
    req_valid = '0;
    repeat (8) tick();

    // Reset with three ops in flight
    tick();
    req_valid = 4'b0001; a_arr[0] = 32'd7; b_arr[0] = 32'd9;
    tick();
    req_valid = 4'b0010; a_arr[1] = 32'd11; b_arr[1] = 32'd13;
    tick();
    req_valid = 4'b0100; a_arr[2] = 32'd17; b_arr[2] = 32'd19;
    tick();
    req_valid = '0;
    reset = 1'b1;
    #2 check("t4_resp_quiet", 64'(resp_valid), 64'h0);
    tick();
    reset = 1'b0;
    #2 check("t4_resp_quiet", 64'(resp_valid), 64'h0);
    for (int k = 5; k <= 8; k++) begin
      tick();
      #2 check("t4_resp_quiet", 64'(resp_valid), 64'h0);
    end
    tick();
    req_valid = 4'hF;
    for (int i = 0; i < NR; i++) begin a_arr[i] = 32'(i + 2); b_arr[i] = 32'(i + 5); end
    #2 check("t4_rr_reset", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0001;
    #2 check("t4_out_cleared", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    repeat (8) tick();

    // Wraparound products
    tick();
    req_valid = 4'b0100; a_arr[2] = 32'h0001_0000; b_arr[2] = 32'h0001_0000;
    tick();
    req_valid = 4'b1000; a_arr[3] = 32'hFFFF_FFFF; b_arr[3] = 32'hFFFF_FFFF;
    tick();
    req_valid = '0;
    tick();
    tick();
    #2;
    check("t5_rv_a", 64'(resp_valid), 64'h4);
    check("t5_wrap0", 64'(resp_data), 64'h0);
    tick();
    #2;
    check("t5_rv_b", 64'(resp_valid), 64'h8);
    check("t5_neg1sq", 64'(resp_data), 64'h1);
    check("t5_id", 64'(resp_id), 64'h3);

    // Mixed request patterns, extreme operands included
    for (int k = 0; k < 24; k++) begin
      tick();
      req_valid = pat_tbl[k % 12];
      for (int i = 0; i < NR; i++) begin
        a_arr[i] = (k % 5 == 0) ? 32'h8000_0000 : 32'(k * 37 - i * 91);
        b_arr[i] = (i == 3) ? 32'hFFFF_FFFF : 32'(k * 13 + i * 1000 - 500);
      end
    end
    tick();
    req_valid = '0;
    repeat (8) tick();

`ifdef MULT_ARB_PERF_EN
    #2;
    check("perf_issue", 64'(perf_issue_cnt), 64'(m_issues));
    check("perf_stall", 64'(perf_stall_cnt), 64'(m_stalls));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
